// File: rtl/clk_sched_pkg.sv
// Shared types and reset constants for the clock-enable scheduler.
// Holds the FSM state enum, the divisor type and the default divisors.
package clk_sched_pkg;

  localparam int CS_NCH   = 3;
  localparam int CS_DIV_W = 8;

  // ch0 in the LSBs: divisors 1, 2, 4
  localparam logic [CS_NCH*CS_DIV_W-1:0] CS_DEF_DIV =
    {8'd4, 8'd2, 8'd1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef logic [CS_DIV_W-1:0] div_t;

endpackage

// File: rtl/clk_sched_chan.sv
// One scheduler channel: period counter, strobe, divided clock, drain hold.
// Ports: clk, rst, go (load preload), active, drain, div, preload -> en, div_clk, held.
module clk_sched_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             active,
  input  logic             drain,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] preload,
  output logic             en,
  output logic             div_clk,
  output logic             held
);

  logic [DIV_W-1:0] cnt;
  logic             tc;

  assign tc = (cnt == div - DIV_W'(1));
  assign en = active && !held && tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      held    <= 1'b0;
    end else if (go) begin
      cnt     <= preload;
      div_clk <= 1'b0;
      held    <= 1'b0;
    end else if (!active) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      held    <= 1'b0;
    end else if (!held) begin
      if (tc) begin
        cnt     <= '0;
        div_clk <= ~div_clk;
        // stop only on the strobe that brings div_clk back low
        held    <= drain && div_clk;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_en_scheduler.sv
// Programmable clock-enable scheduler: FSM, single-slot config handshake, NCH channels.
// Ports: clk, rst, start, stop, cfg_valid/cfg_ready/cfg_ch/cfg_div, cfg_err, en_o, div_clk_o, busy.
// CLK_SCHED_PHASE_EN adds cfg_phase, a per-channel start offset.
module clk_en_scheduler
  import clk_sched_pkg::*;
#(
  parameter int NCH = CS_NCH,
  parameter int DIV_W = CS_DIV_W,
  parameter logic [NCH*DIV_W-1:0] DEF_DIV = CS_DEF_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]         cfg_div,
`ifdef CLK_SCHED_PHASE_EN
  input  logic [DIV_W-1:0]         cfg_phase,
`endif
  output logic                     cfg_err,
  output logic [NCH-1:0]           en_o,
  output logic [NCH-1:0]           div_clk_o,
  output logic                     busy
);

  state_t state;
  state_t state_nxt;
  logic   go;
  logic   drain;

  logic [NCH-1:0]            held;
  logic [NCH-1:0][DIV_W-1:0] div_q;
  logic [NCH-1:0][DIV_W-1:0] preload;

  logic                   pend;
  logic [$clog2(NCH)-1:0] pend_ch;
  logic [DIV_W-1:0]       pend_div;
  logic                   acc;
  logic                   bad;
  logic                   apply;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // stop has priority over start, so start&stop in IDLE does nothing
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          go        = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (&held) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign drain     = (state == DRAIN);
  assign cfg_ready = !pend;

  assign acc = cfg_valid && cfg_ready;
  assign bad = (cfg_div == '0) || (int'(cfg_ch) >= NCH);

  // running channels take the update only at their terminal count
  assign apply = pend && ((state == IDLE) || en_o[pend_ch]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_ch  <= '0;
      pend_div <= '0;
      cfg_err  <= 1'b0;
      div_q    <= DEF_DIV;
    end else begin
      cfg_err <= acc && bad;
      if (apply) begin
        div_q[pend_ch] <= pend_div;
        pend           <= 1'b0;
      end
      if (acc && !bad) begin
        pend     <= 1'b1;
        pend_ch  <= cfg_ch;
        pend_div <= cfg_div;
      end
    end
  end

`ifdef CLK_SCHED_PHASE_EN
  logic [DIV_W-1:0]          pend_ph;
  logic [NCH-1:0][DIV_W-1:0] ph_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_ph <= '0;
      ph_q    <= '0;
    end else begin
      if (apply) ph_q[pend_ch] <= pend_ph;
      if (acc && !bad) pend_ph <= cfg_phase;
    end
  end

  always_comb begin
    preload = '0;
    for (int i = 0; i < NCH; i++) begin
      preload[i] = ph_q[i] % div_q[i];
    end
  end
`else
  assign preload = '0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_sched_chan #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .go      (go),
      .active  (busy),
      .drain   (drain),
      .div     (div_q[i]),
      .preload (preload[i]),
      .en      (en_o[i]),
      .div_clk (div_clk_o[i]),
      .held    (held[i])
    );
  end

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Self-checking bench for clk_en_scheduler.
// Expected output vectors are queued per cycle and compared on the falling edge.
module tb_clk_en_scheduler;

  typedef logic [8:0] obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
`ifdef CLK_SCHED_PHASE_EN
  logic [7:0] cfg_phase;
`endif
  logic       cfg_err;
  logic [2:0] en_o;
  logic [2:0] div_clk_o;
  logic       busy;

  obs_t expq[$];
  obs_t obs;
  obs_t exp_v;
  int   checks = 0;
  int   errors = 0;

  localparam obs_t IDLE_V = 9'b0_1_0_000_000;

  always #5 clk = ~clk;

  clk_en_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLK_SCHED_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .cfg_err   (cfg_err),
    .en_o      (en_o),
    .div_clk_o (div_clk_o),
    .busy      (busy)
  );

  assign obs = {cfg_err, cfg_ready, busy, div_clk_o, en_o};

  // channel started at RUN cycle 1: {div_clk, en} in RUN cycle k
  function automatic logic [1:0] chan_exp(int k, int d);
    logic dc;
    logic en;
    dc = (((k - 1) / d) % 2) != 0;
    en = (k % d) == 0;
    return {dc, en};
  endfunction

  function automatic obs_t pack_obs(logic err, logic rdy,
                                    logic bsy, logic [1:0] c0,
                                    logic [1:0] c1, logic [1:0] c2);
    return {err, rdy, bsy, c2[1], c1[1], c0[1],
            c2[0], c1[0], c0[0]};
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLK_SCHED_PHASE_EN
    cfg_phase = '0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLK_SCHED_PHASE_EN
    cfg_phase = '0;
`endif
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      rst = (k < 2);
      expq.push_back(IDLE_V);
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset k=%0d got %b want %b", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_run_defaults();
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      start = (k == 0);
      if (k == 0) expq.push_back(IDLE_V);
      else expq.push_back(pack_obs(1'b0, 1'b1, 1'b1,
             chan_exp(k, 1), chan_exp(k, 2), chan_exp(k, 4)));
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL run_defaults k=%0d got %b want %b",
                 k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_cfg_update();
    logic [1:0] c2;
    logic       rdy;
    do_reset();
    for (int k = 0; k <= 26; k++) begin
      start     = (k == 0);
      cfg_valid = (k == 2);
      cfg_ch    = 2'd2;
      cfg_div   = 8'd6;
      if (k <= 4) c2 = chan_exp(k, 4);
      else begin
        c2 = chan_exp(k - 4, 6);
        c2[1] = ~c2[1];
      end
      rdy = !(k == 3 || k == 4);
      if (k == 0) expq.push_back(IDLE_V);
      else expq.push_back(pack_obs(1'b0, rdy, 1'b1,
             chan_exp(k, 1), chan_exp(k, 2), c2));
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL cfg_update k=%0d got %b want %b",
                 k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_cfg_error();
    int j;
    do_reset();
    for (int k = 0; k <= 14; k++) begin
      cfg_valid = (k < 2);
      cfg_ch    = (k == 0) ? 2'd1 : 2'd3;
      cfg_div   = (k == 0) ? 8'd0 : 8'd5;
      start     = (k == 3);
      j = k - 3;
      if (k <= 3)
        expq.push_back({(k == 1 || k == 2), IDLE_V[7:0]});
      else expq.push_back(pack_obs(1'b0, 1'b1, 1'b1,
             chan_exp(j, 1), chan_exp(j, 2), chan_exp(j, 4)));
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL cfg_error k=%0d got %b want %b",
                 k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_stop_drain(input int s);
    int         d[3];
    int         last[3];
    int         maxl;
    logic [1:0] c[3];
    d    = '{1, 2, 4};
    maxl = 0;
    for (int ch = 0; ch < 3; ch++) begin
      int k;
      k = s + 1;
      while (!((k % d[ch]) == 0 &&
               (((k - 1) / d[ch]) % 2) == 1)) k++;
      last[ch] = k;
      if (k > maxl) maxl = k;
    end
    do_reset();
    for (int k = 0; k <= maxl + 5; k++) begin
      start = (k == 0) || (k == s + 2);
      stop  = (k == s);
      for (int ch = 0; ch < 3; ch++)
        c[ch] = (k >= 1 && k <= last[ch]) ?
                chan_exp(k, d[ch]) : 2'b00;
      expq.push_back(pack_obs(1'b0, 1'b1,
        (k >= 1 && k <= maxl + 1), c[0], c[1], c[2]));
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stop_drain s=%0d k=%0d got %b want %b",
                 s, k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_start_stop_rst();
    logic [1:0] c2;
    logic       rdy;
    int         j;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      start = (k == 0);
      stop  = (k == 0);
      expq.push_back(IDLE_V);
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL start_stop_idle k=%0d got %b want %b",
                 k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    stop = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      start     = (k == 0) || (k == 9);
      rst       = (k == 7);
      cfg_valid = (k == 1) || (k == 6);
      cfg_ch    = (k == 1) ? 2'd2 : 2'd1;
      cfg_div   = (k == 1) ? 8'd7 : 8'd5;
      rdy = !((k >= 2 && k <= 4) || k == 7);
      if (k <= 4) c2 = chan_exp(k, 4);
      else begin
        c2 = chan_exp(k - 4, 7);
        c2[1] = ~c2[1];
      end
      j = k - 9;
      if (k == 0 || k == 8 || k == 9) expq.push_back(IDLE_V);
      else if (k <= 7) expq.push_back(pack_obs(1'b0, rdy, 1'b1,
             chan_exp(k, 1), chan_exp(k, 2), c2));
      else expq.push_back(pack_obs(1'b0, 1'b1, 1'b1,
             chan_exp(j, 1), chan_exp(j, 2), chan_exp(j, 4)));
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rst_midrun k=%0d got %b want %b",
                 k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    rst       = 1'b0;
    cfg_valid = 1'b0;
  endtask

`ifdef CLK_SCHED_PHASE_EN
  task automatic test_phase();
    int j;
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      cfg_valid = (k == 0);
      cfg_ch    = 2'd1;
      cfg_div   = 8'd4;
      cfg_phase = 8'd3;
      start     = (k == 2);
      j = k - 2;
      if (k <= 2) expq.push_back({1'b0, (k != 1), IDLE_V[6:0]});
      else expq.push_back(pack_obs(1'b0, 1'b1, 1'b1,
             chan_exp(j, 1), chan_exp(j + 3, 4), chan_exp(j, 4)));
      @(negedge clk);
      exp_v = expq.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL phase k=%0d got %b want %b", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_run_defaults();
    test_cfg_update();
    test_cfg_error();
    test_stop_drain(7);
    test_stop_drain(5);
    test_start_stop_rst();
`ifdef CLK_SCHED_PHASE_EN
    test_phase();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
